poly_tone_gen: RTL and testbench

//  Parametrised N-voice successor to the single-tone piano core: 12 note keys plus octave select

---
 rtl/poly_tone_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_poly_tone_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: N-voice square-wave tone generator. Twelve synchronized note keys
// plus an octave select drive NUM_VOICES voices, in mono (lowest key wins) or poly
// (first-free voice allocator) mode. Voices are summed into a registered level bus
// and converted to a first-order sigma-delta PDM pin.

// One square-wave voice: clear has priority over start, start over free-running.
module ptg_voice #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       start_tag,
  input  logic [DIV_W-1:0] hp,
  output logic             sq,
  output logic             busy,
  output logic [3:0]       tag
);
  logic [DIV_W-1:0] cnt;

  // a started voice counts from zero with sq low, so its first rise lands hp cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sq   <= 1'b0;
      busy <= 1'b0;
      tag  <= '0;
    end else if (clr) begin
      cnt  <= '0;
      sq   <= 1'b0;
      busy <= 1'b0;
      tag  <= '0;
    end else if (start) begin
      cnt  <= '0;
      sq   <= 1'b0;
      busy <= 1'b1;
      tag  <= start_tag;
    end else if (busy) begin
      if (cnt == hp - 1'b1) begin
        cnt <= '0;
        sq  <= ~sq;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module poly_tone_gen #(
  parameter  int NUM_VOICES = 4,
  parameter  int DIV_W      = 16,
  parameter  int OCT_W      = 4,
  parameter  int MAX_OCT    = 8,
  localparam int LVL_W      = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           keys,
  input  logic [OCT_W-1:0]      octave,
  input  logic                  mode,
  output logic [NUM_VOICES-1:0] voice_sq,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic [LVL_W-1:0]      level,
  output logic                  pdm_out,
  output logic                  full
);
  localparam int ACC_W = $clog2(2 * NUM_VOICES);
  localparam int S_W   = ACC_W + 1;
  localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [11:0]      keys_s1, ks;
  logic             mode_r, mode_p;
  logic [OCT_W-1:0] oct_r, oct_p, oct_sat;
  logic             chg;

  logic [NUM_VOICES-1:0][3:0]       tag;
  logic [NUM_VOICES-1:0][DIV_W-1:0] hp;
  logic [NUM_VOICES-1:0]            clr, start, key_on;
  logic [3:0]                       start_tag;

  logic [11:0]      held, pend;
  logic             new_vld, low_vld, free_vld;
  logic [3:0]       new_key, low_key;
  logic [VID_W-1:0] free_v;

  logic [LVL_W-1:0] pop;
  logic [ACC_W-1:0] acc;
  logic [S_W-1:0]   pdm_sum;

  // octave-0 half periods in clocks, C..B
  function automatic logic [DIV_W-1:0] rom_hp(input logic [3:0] k);
    case (k)
      4'd0:    rom_hp = DIV_W'(30581);
      4'd1:    rom_hp = DIV_W'(28860);
      4'd2:    rom_hp = DIV_W'(27241);
      4'd3:    rom_hp = DIV_W'(25714);
      4'd4:    rom_hp = DIV_W'(24271);
      4'd5:    rom_hp = DIV_W'(22910);
      4'd6:    rom_hp = DIV_W'(21622);
      4'd7:    rom_hp = DIV_W'(20408);
      4'd8:    rom_hp = DIV_W'(19264);
      4'd9:    rom_hp = DIV_W'(18182);
      4'd10:   rom_hp = DIV_W'(17161);
      4'd11:   rom_hp = DIV_W'(16198);
      default: rom_hp = DIV_W'(16198);
    endcase
  endfunction

  // keys are raw pins: two flops; mode/octave get one sample flop plus a history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_s1 <= '0;
      ks      <= '0;
      mode_r  <= 1'b0;
      mode_p  <= 1'b0;
      oct_r   <= '0;
      oct_p   <= '0;
    end else begin
      keys_s1 <= keys;
      ks      <= keys_s1;
      mode_r  <= mode;
      mode_p  <= mode_r;
      oct_r   <= octave;
      oct_p   <= oct_r;
    end
  end

  // any change of the sampled mode/octave flushes every voice for one cycle
  assign chg     = (mode_r != mode_p) || (oct_r != oct_p);
  assign oct_sat = (oct_r > OCT_W'(MAX_OCT)) ? OCT_W'(MAX_OCT) : oct_r;

  // per-voice half period follows its tag; octave is stable for a voice's lifetime
  always_comb begin
    hp = '0;
    for (int v = 0; v < NUM_VOICES; v++) hp[v] = rom_hp(tag[v]) >> oct_sat;
  end

  // allocator: which keys are held, which voices lost their key, lowest pending key / free voice
  always_comb begin
    held      = '0;
    key_on    = '0;
    new_vld   = 1'b0;
    new_key   = '0;
    low_vld   = 1'b0;
    low_key   = '0;
    free_vld  = 1'b0;
    free_v    = '0;
    clr       = '0;
    start     = '0;
    start_tag = '0;
    for (int k = 0; k < 12; k++) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_busy[v] && tag[v] == 4'(k)) begin
          held[k]   = 1'b1;
          key_on[v] = key_on[v] | ks[k];
        end
      end
    end
    pend = ks & ~held;
    for (int k = 11; k >= 0; k--) begin
      if (pend[k]) begin
        new_vld = 1'b1;
        new_key = 4'(k);
      end
      if (ks[k]) begin
        low_vld = 1'b1;
        low_key = 4'(k);
      end
    end
    // free voice is judged on current state, so a voice freed this cycle waits one cycle
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_busy[v]) begin
        free_vld = 1'b1;
        free_v   = VID_W'(v);
      end
    end
    if (mode_r) begin
      start_tag = new_key;
      for (int v = 0; v < NUM_VOICES; v++) begin
        clr[v]   = chg | (voice_busy[v] & ~key_on[v]);
        start[v] = ~chg & new_vld & free_vld & (free_v == VID_W'(v));
      end
    end else begin
      start_tag = low_key;
      clr       = '1;
      clr[0]    = chg | ~low_vld;
      start[0]  = ~chg & low_vld & (~voice_busy[0] | (tag[0] != low_key));
    end
  end

  assign full = mode_r & (|pend) & (&voice_busy);

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    ptg_voice #(.DIV_W(DIV_W)) u_voice (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr[v]),
      .start     (start[v]),
      .start_tag (start_tag),
      .hp        (hp[v]),
      .sq        (voice_sq[v]),
      .busy      (voice_busy[v]),
      .tag       (tag[v])
    );
  end

  // popcount of the live square waves
  always_comb begin
    pop = '0;
    for (int v = 0; v < NUM_VOICES; v++) pop = pop + LVL_W'(voice_sq[v]);
  end

  assign pdm_sum = S_W'(acc) + S_W'(level);

  // level register and first-order sigma-delta: density of ones is level/NUM_VOICES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= '0;
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      level <= pop;
      if (pdm_sum >= S_W'(NUM_VOICES)) begin
        pdm_out <= 1'b1;
        acc     <= ACC_W'(pdm_sum - S_W'(NUM_VOICES));
      end else begin
        pdm_out <= 1'b0;
        acc     <= ACC_W'(pdm_sum);
      end
    end
  end
endmodule

// File: tb/tb_poly_tone_gen.sv
// Bench for poly_tone_gen: cycle model built from voice ages, directed scenarios, random keys.
module tb_poly_tone_gen;
  localparam int NV = 4;

  logic          clk;
  logic          rst;
  logic [11:0]   keys;
  logic [3:0]    octave;
  logic          mode;
  logic [NV-1:0] voice_sq, voice_busy;
  logic [2:0]    level;
  logic          pdm_out, full;

  int n_chk = 0;
  int n_fail = 0;

  poly_tone_gen #(.NUM_VOICES(NV), .DIV_W(16), .OCT_W(4), .MAX_OCT(8)) dut (
    .clk(clk), .rst(rst), .keys(keys), .octave(octave), .mode(mode),
    .voice_sq(voice_sq), .voice_busy(voice_busy), .level(level),
    .pdm_out(pdm_out), .full(full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int rom [12] = '{30581, 28860, 27241, 25714, 24271, 22910, 21622, 20408,
                   19264, 18182, 17161, 16198};

  function automatic int hp_of(input int k, input int o);
    return rom[k] >> ((o > 8) ? 8 : o);
  endfunction

  logic [11:0] m_s1, m_ks;
  logic        m_mr, m_mp;
  logic [3:0]  m_or, m_op;
  bit          m_busy [NV];
  int          m_key [NV], m_age [NV], m_hp [NV];
  int          m_level, m_acc;
  bit          m_pdm;

  // a voice's square wave is a pure function of how long it has held its key
  function automatic bit m_sq(input int v);
    return m_busy[v] && (((m_age[v] / m_hp[v]) % 2) == 1);
  endfunction

  function automatic bit m_full();
    bit held [12];
    bit all_busy = 1'b1;
    bit pend = 1'b0;
    for (int k = 0; k < 12; k++) held[k] = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (m_busy[v]) held[m_key[v]] = 1'b1;
      else all_busy = 1'b0;
    end
    for (int k = 0; k < 12; k++) if (m_ks[k] && !held[k]) pend = 1'b1;
    return m_mr && pend && all_busy;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int  pop, s, nk, fv, lowk;
    bit  chg;
    bit  ob [NV];
    bit  held [12];
    if (rst) begin
      m_s1 = '0; m_ks = '0; m_mr = 0; m_mp = 0; m_or = '0; m_op = '0;
      for (int v = 0; v < NV; v++) begin
        m_busy[v] = 0; m_key[v] = 0; m_age[v] = 0; m_hp[v] = 1;
      end
      m_level = 0; m_acc = 0; m_pdm = 0;
    end else begin
      pop = 0;
      for (int v = 0; v < NV; v++) pop += int'(m_sq(v));
      s = m_acc + m_level;
      if (s >= NV) begin m_pdm = 1; m_acc = s - NV; end
      else begin m_pdm = 0; m_acc = s; end
      m_level = pop;
      chg = (m_mr != m_mp) || (m_or != m_op);
      for (int v = 0; v < NV; v++) ob[v] = m_busy[v];
      if (chg) begin
        for (int v = 0; v < NV; v++) m_busy[v] = 0;
      end else if (m_mr) begin
        for (int k = 0; k < 12; k++) held[k] = 0;
        for (int v = 0; v < NV; v++) if (ob[v]) held[m_key[v]] = 1;
        for (int v = 0; v < NV; v++)
          if (ob[v]) begin
            if (!m_ks[m_key[v]]) m_busy[v] = 0;
            else m_age[v]++;
          end
        nk = -1;
        for (int k = 0; k < 12; k++) if (nk < 0 && m_ks[k] && !held[k]) nk = k;
        fv = -1;
        for (int v = 0; v < NV; v++) if (fv < 0 && !ob[v]) fv = v;
        if (nk >= 0 && fv >= 0) begin
          m_busy[fv] = 1; m_key[fv] = nk; m_age[fv] = 0; m_hp[fv] = hp_of(nk, int'(m_or));
        end
      end else begin
        lowk = -1;
        for (int k = 0; k < 12; k++) if (lowk < 0 && m_ks[k]) lowk = k;
        for (int v = 1; v < NV; v++) m_busy[v] = 0;
        if (lowk < 0) m_busy[0] = 0;
        else if (ob[0] && m_key[0] == lowk) m_age[0]++;
        else begin
          m_busy[0] = 1; m_key[0] = lowk; m_age[0] = 0; m_hp[0] = hp_of(lowk, int'(m_or));
        end
      end
      m_op = m_or; m_or = octave;
      m_mp = m_mr; m_mr = mode;
      m_ks = m_s1; m_s1 = keys;
    end
  end

  // every cycle out of reset, the DUT must match the model
  always @(negedge clk) begin : compare
    logic [NV-1:0] eb, es;
    if (!rst) begin
      eb = '0; es = '0;
      for (int v = 0; v < NV; v++) begin
        eb[v] = m_busy[v];
        es[v] = m_sq(v);
      end
      chk("model_busy", 32'(voice_busy), 32'(eb));
      chk("model_sq", 32'(voice_sq), 32'(es));
      chk("model_level", 32'(level), 32'(m_level));
      chk("model_pdm", 32'(pdm_out), 32'(m_pdm));
      chk("model_full", 32'(full), 32'(m_full()));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sq0(input logic val, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (voice_sq[0] !== val && n < bound);
  endtask

  initial begin
    int n1, n2, mx, ones;
    rst = 1'b1; keys = '0; mode = 1'b1; octave = 4'd4;
    negs(3);
    chk("reset_busy", 32'(voice_busy), 0);
    chk("reset_sq", 32'(voice_sq), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_pdm", 32'(pdm_out), 0);
    chk("reset_full", 32'(full), 0);
    rst = 1'b0;
    negs(5);

    // T1: A4 in poly mode
    keys = 12'h200;
    negs(2);
    chk("t1_busy_early", 32'(voice_busy), 0);
    negs(1);
    chk("t1_busy_cyc3", 32'(voice_busy), 1);
    wait_sq0(1'b1, 5000, n1);
    chk("t1_first_rise", n1, 1136);
    wait_sq0(1'b0, 5000, n1);
    chk("t1_half_period", n1, 1136);
    keys = '0;
    negs(3);
    chk("t1_release_busy", 32'(voice_busy), 0);
    chk("t1_release_sq", 32'(voice_sq), 0);

    // T2: chord C E G at octave 8
    octave = 4'd8;
    negs(4);
    keys = 12'h091;
    negs(3);
    chk("t2_assign0", 32'(voice_busy), 1);
    negs(1);
    chk("t2_assign1", 32'(voice_busy), 3);
    negs(1);
    chk("t2_assign2", 32'(voice_busy), 7);
    mx = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (int'(level) > mx) mx = int'(level);
    end
    chk("t2_level_max", mx, 3);
    keys = '0;
    negs(5);

    // T3: five keys on four voices
    keys = 12'h01F;
    negs(8);
    chk("t3_all_busy", 32'(voice_busy), 15);
    chk("t3_full", 32'(full), 1);
    keys = 12'h01E;
    negs(3);
    chk("t3_freed", 32'(voice_busy), 14);
    chk("t3_full_freed", 32'(full), 0);
    negs(1);
    chk("t3_reassigned", 32'(voice_busy), 15);
    chk("t3_full_clear", 32'(full), 0);
    keys = '0;
    negs(5);

    // T4: mono, E and G held, E wins; release E -> restart on G
    mode = 1'b0;
    negs(4);
    keys = 12'h090;
    wait_sq0(1'b1, 1000, n1);
    wait_sq0(1'b0, 1000, n1);
    wait_sq0(1'b1, 1000, n2);
    chk("t4_period", n1 + n2, 188);
    keys = 12'h080;
    negs(3);
    chk("t4_restart_sq", 32'(voice_sq), 0);
    chk("t4_restart_busy", 32'(voice_busy), 1);
    wait_sq0(1'b1, 1000, n1);
    chk("t4_g_rise", n1, 79);
    keys = '0;
    negs(4);

    // T6: octave 15 saturates to 8, then async reset mid-note
    octave = 4'd15;
    negs(4);
    keys = 12'h200;
    negs(3);
    chk("t6_busy", 32'(voice_busy), 1);
    wait_sq0(1'b1, 1000, n1);
    chk("t6_sat_rise", n1, 71);
    negs(5);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(voice_busy), 0);
    chk("t6_rst_sq", 32'(voice_sq), 0);
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_pdm", 32'(pdm_out), 0);
    keys = '0;
    negs(2);
    #2 rst = 1'b0;

    // level 0 keeps the PDM pin low
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    chk("t5_pdm_idle", ones, 0);

    // random keys, occasional mode/octave changes
    mode = 1'b1;
    octave = 4'd8;
    negs(4);
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) keys = keys ^ (12'd1 << $urandom_range(0, 11));
      if ($urandom_range(0, 1999) == 0) mode = ~mode;
      if ($urandom_range(0, 999) == 0) octave = 4'($urandom_range(6, 15));
    end
    keys = '0;
    negs(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
